regfile_2w_sb: RTL and testbench
================================

Name: regfile_2w_sb

Overview:
Parametrised multi-port register file for the RISC datapath. It supersedes the single-write register block with:
- two write ports with defined priority;
- optional write-to-read bypass;
- synchronous clear;
- a runtime-selectable debug tap;
- a per-register busy scoreboard.

Decode uses the scoreboard for hazard stalls; the second write port serves a dual-writeback pipeline.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width
NUM_REGS, 32, number of architectural registers (must be ≤ 2**ADDR_W)
ZERO_REG, 1, 1 = register 0 is hardwired to zero and never written or marked busy
BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
ra1  input  ADDR_W  read address, port 1
ra2  input  ADDR_W  read address, port 2
rd1  output  DATA_W  read data, port 1 (combinational)
rd2  output  DATA_W  read data, port 2 (combinational)
we_a  input  1  write enable, port A
wa_a  input  ADDR_W  write address, port A
wd_a  input  DATA_W  write data, port A
we_b  input  1  write enable, port B
wa_b  input  ADDR_W  write address, port B
wd_b  input  DATA_W  write data, port B
iss_en  input  1  issue strobe: mark iss_rd busy
iss_rd  input  ADDR_W  destination register being issued
busy1  output  1  busy flag of ra1 (combinational)
busy2  output  1  busy flag of ra2 (combinational)
dbg_sel  input  ADDR_W  debug tap register select
dbg_data  output  DATA_W  contents of register dbg_sel (registered, 1-cycle latency)

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset: on a rising edge with rst=1:
  - all NUM_REGS registers are cleared to 0;
  - all busy bits are cleared to 0;
  - dbg_data is cleared to 0;
  - writes and issues in that cycle are discarded.
- rd1/rd2 read 0 on the cycle after reset.
- Write:
  - On a rising edge, port X writes regfile[wa_X] <= wd_X when we_X=1, wa_X < NUM_REGS, and the target is not (ZERO_REG=1 and wa_X=0).
  - Addresses ≥ NUM_REGS are ignored for writes.
- Write collision: we_a=we_b=1 with wa_a==wa_b → port B's data is stored; port A is dropped.
- Read:
  - rdN = 0 if (ZERO_REG=1 and raN=0) or raN ≥ NUM_REGS.
  - Otherwise, with BYPASS=1 the first match applies:
    - a qualifying port-B write to raN → wd_b;
    - else a qualifying port-A write to raN → wd_a;
    - else the stored value.
  - With BYPASS=0: the stored value; the new value is visible the cycle after the write edge.
- Scoreboard (one busy bit per register):
  - Set: iss_en=1 sets busy[iss_rd] at the edge.
  - Clear: each qualifying write clears busy[wa_X] at the edge.
  - Issue and write to the same register in the same cycle → busy ends 1 (the new issue wins).
  - iss_rd=0 with ZERO_REG=1, or iss_rd ≥ NUM_REGS, is ignored.
  - busyN = busy[raN], 0 for the zero register or an out-of-range address.
  - No bypass on busy: a clear takes effect the cycle after the write edge.
- Debug tap: dbg_data <= (register dbg_sel after this edge's writes are applied) every cycle; out-of-range or zero-register select → 0.
- Reset mid-operation: rst overrides any concurrent we_a/we_b/iss_en in the same cycle; nothing from that cycle persists.
- No X on any output after the first reset edge. Register contents before the first reset are undefined; the busy bits must be reset.

Test Plan:
1. Reset: preload registers, assert rst for 1 cycle → rd1/rd2=0 for every address; busy1/busy2=0; dbg_data=0 next cycle.
2. Dual write: we_a: r5←0x11111111 and we_b: r6←0x22222222 in one cycle → next cycle ra1=5 gives 0x11111111, ra2=6 gives 0x22222222. Then wa_a=wa_b=7 with wd_a=0xAAAA, wd_b=0xBBBB → r7 reads 0xBBBB.
3. Bypass: BYPASS=1, ra1=9 while we_a writes r9←0xDEADBEEF → rd1=0xDEADBEEF in the same cycle. Same stimulus with BYPASS=0 → rd1 shows the old value, then 0xDEADBEEF next cycle.
4. Zero register: ZERO_REG=1, we_b writes r0←0xFFFFFFFF and iss_en with iss_rd=0 → rd1 (ra1=0)=0, busy1=0, dbg_sel=0 gives dbg_data=0.
5. Scoreboard:
   - iss_en with iss_rd=12 → busy1 (ra1=12)=1 next cycle.
   - we_a to r12 → busy1=0 the cycle after.
   - iss_en with iss_rd=12 plus we_b to r12 in the same cycle → busy stays 1.
6. Reset mid-operation: rst=1 together with we_a r3←0x55, we_b r4←0x66, iss_en iss_rd=3 → afterwards r3=0, r4=0, busy[3]=0.

Source files
------------

// File: rtl/regfile_2w_sb_if.sv
// Bus bundle for regfile_2w_sb.
// It groups the two read ports, the two write ports, the issue strobe for the
// scoreboard, the busy flags and the debug tap. The clock and reset stay outside
// the bundle.
//   master : drives addresses, write ports, issue and debug select;
//            receives read data, busy flags and debug data
//   slave  : the register file
interface regfile_2w_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              we_a;
  logic [ADDR_W-1:0] wa_a;
  logic [DATA_W-1:0] wd_a;
  logic              we_b;
  logic [ADDR_W-1:0] wa_b;
  logic [DATA_W-1:0] wd_b;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_rd;
  logic              busy1;
  logic              busy2;
  logic [ADDR_W-1:0] dbg_sel;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output ra1, ra2, we_a, wa_a, wd_a, we_b, wa_b, wd_b, iss_en, iss_rd, dbg_sel,
    input  rd1, rd2, busy1, busy2, dbg_data
  );

  modport slave (
    input  ra1, ra2, we_a, wa_a, wd_a, we_b, wa_b, wd_b, iss_en, iss_rd, dbg_sel,
    output rd1, rd2, busy1, busy2, dbg_data
  );
endinterface

// File: rtl/regfile_2w_sb.sv
// regfile_2w_sb: a register file with two write ports and a busy scoreboard.
// It has two combinational read ports. Port B has priority over port A when both
// write the same register. Write data can be forwarded to the read ports in the
// same cycle. Each register has a busy bit that an issue sets and a write clears.
// A debug tap returns one register with one cycle of latency.
// Ports:
//   clk : rising-edge clock for all state
//   rst : synchronous active-high reset. It clears the registers, the busy bits
//         and dbg_data.
//   bus : regfile_2w_sb_if.slave. It carries ra1/ra2 -> rd1/rd2 and busy1/busy2,
//         the write ports A and B, iss_en/iss_rd, and dbg_sel -> dbg_data.
module regfile_2w_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic           clk,
  input  logic           rst,
  regfile_2w_sb_if.slave bus
);

  // The compare is one bit wider than the address, so NUM_REGS == 2**ADDR_W
  // still works.
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  // An address is usable when it is in range and is not the hardwired zero
  // register. The same check qualifies writes, issues, reads and the debug tap.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic wr_a_ok;
  logic wr_b_ok;
  logic iss_ok;

  assign wr_a_ok = bus.we_a   && addr_ok(bus.wa_a);
  assign wr_b_ok = bus.we_b   && addr_ok(bus.wa_b);
  assign iss_ok  = bus.iss_en && addr_ok(bus.iss_rd);

  logic [DATA_W-1:0] store [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec;

  // One storage slot and one busy bit per register. Each slot decodes its own
  // hits. Port B is tested first, so it wins a collision. For the busy bit, a
  // new issue wins over a write that clears the bit in the same cycle.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);

    logic              hit_a;
    logic              hit_b;
    logic              hit_iss;
    logic [DATA_W-1:0] val_reg;
    logic              busy_reg;

    assign hit_a   = wr_a_ok && (bus.wa_a   == IDX);
    assign hit_b   = wr_b_ok && (bus.wa_b   == IDX);
    assign hit_iss = iss_ok  && (bus.iss_rd == IDX);

    always_ff @(posedge clk) begin
      if (rst) begin
        val_reg  <= '0;
        busy_reg <= 1'b0;
      end else begin
        if (hit_b) begin
          val_reg <= bus.wd_b;
        end else if (hit_a) begin
          val_reg <= bus.wd_a;
        end
        if (hit_iss) begin
          busy_reg <= 1'b1;
        end else if (hit_a || hit_b) begin
          busy_reg <= 1'b0;
        end
      end
    end

    assign store[gi]    = val_reg;
    assign busy_vec[gi] = busy_reg;
  end

  // Read ports. Forwarding applies only to data. The busy flag always shows
  // the stored bit.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              bz;

    assign ra = (gi == 0) ? bus.ra1 : bus.ra2;

    always_comb begin
      rd = '0;
      bz = 1'b0;
      if (addr_ok(ra)) begin
        rd = store[ra];
        bz = busy_vec[ra];
        if (BYPASS != 0) begin
          if (wr_b_ok && (bus.wa_b == ra)) begin
            rd = bus.wd_b;
          end else if (wr_a_ok && (bus.wa_a == ra)) begin
            rd = bus.wd_a;
          end
        end
      end
    end
  end

  assign bus.rd1   = g_rd[0].rd;
  assign bus.rd2   = g_rd[1].rd;
  assign bus.busy1 = g_rd[0].bz;
  assign bus.busy2 = g_rd[1].bz;

  // The debug tap captures the value the register holds after this edge. For
  // that reason it always forwards this cycle's writes, whatever BYPASS is.
  logic [DATA_W-1:0] dbg_next;
  logic [DATA_W-1:0] dbg_reg;

  always_comb begin
    dbg_next = '0;
    if (addr_ok(bus.dbg_sel)) begin
      if (wr_b_ok && (bus.wa_b == bus.dbg_sel)) begin
        dbg_next = bus.wd_b;
      end else if (wr_a_ok && (bus.wa_a == bus.dbg_sel)) begin
        dbg_next = bus.wd_a;
      end else begin
        dbg_next = store[bus.dbg_sel];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_reg <= '0;
    end else begin
      dbg_reg <= dbg_next;
    end
  end

  assign bus.dbg_data = dbg_reg;

endmodule

// File: tb/tb_regfile_2w_sb.sv
// Directed testbench for regfile_2w_sb.
// The same stimulus drives two instances:
//   u_dut : BYPASS=1, 32 registers
//   u_nb  : BYPASS=0, 24 registers, so that out-of-range writes and issues can
//           be exercised.
module tb_regfile_2w_sb;
  logic clk = 1'b0;
  logic rst;

  logic [4:0]  ra1, ra2, wa_a, wa_b, iss_rd, dbg_sel;
  logic [31:0] wd_a, wd_b;
  logic        we_a, we_b, iss_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_2w_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
  regfile_2w_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

  assign bus_b.ra1 = ra1;       assign bus_n.ra1 = ra1;
  assign bus_b.ra2 = ra2;       assign bus_n.ra2 = ra2;
  assign bus_b.we_a = we_a;     assign bus_n.we_a = we_a;
  assign bus_b.wa_a = wa_a;     assign bus_n.wa_a = wa_a;
  assign bus_b.wd_a = wd_a;     assign bus_n.wd_a = wd_a;
  assign bus_b.we_b = we_b;     assign bus_n.we_b = we_b;
  assign bus_b.wa_b = wa_b;     assign bus_n.wa_b = wa_b;
  assign bus_b.wd_b = wd_b;     assign bus_n.wd_b = wd_b;
  assign bus_b.iss_en = iss_en; assign bus_n.iss_en = iss_en;
  assign bus_b.iss_rd = iss_rd; assign bus_n.iss_rd = iss_rd;
  assign bus_b.dbg_sel = dbg_sel; assign bus_n.dbg_sel = dbg_sel;

  regfile_2w_sb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  regfile_2w_sb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(24), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .bus(bus_n.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits past the next rising edge. Inputs change and outputs are sampled
  // away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a = 1'b0; we_b = 1'b0; iss_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ra1 = '0; ra2 = '0; wa_a = '0; wa_b = '0; iss_rd = '0; dbg_sel = '0;
    wd_a = '0; wd_b = '0;
    idle();
    tick(); tick();
    rst = 1'b0;

    // 1. Preload, then reset. Afterwards everything reads back as zero.
    we_a = 1'b1; wa_a = 5'd5;  wd_a = 32'h0000_1234;
    we_b = 1'b1; wa_b = 5'd20; wd_b = 32'h0000_5678;
    iss_en = 1'b1; iss_rd = 5'd20; dbg_sel = 5'd5;
    tick();
    idle();
    ra1 = 5'd5; ra2 = 5'd20;
    #1;
    chk("preload_rd1", bus_b.rd1, 32'h0000_1234);
    chk("preload_busy2", {31'b0, bus_b.busy2}, 32'd1);
    chk("preload_dbg", bus_b.dbg_data, 32'h0000_1234);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_dbg", bus_b.dbg_data, 32'h0);
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      #1;
      chk($sformatf("reset_rd1_%0d", a), bus_b.rd1, 32'h0);
      chk($sformatf("reset_rd2_%0d", a), bus_b.rd2, 32'h0);
      chk($sformatf("reset_busy_%0d", a), {30'b0, bus_b.busy1, bus_b.busy2}, 32'h0);
      chk($sformatf("reset_nb_rd1_%0d", a), bus_n.rd1, 32'h0);
    end

    // 2. Dual write to different registers, then a write collision.
    we_a = 1'b1; wa_a = 5'd5; wd_a = 32'h1111_1111;
    we_b = 1'b1; wa_b = 5'd6; wd_b = 32'h2222_2222;
    tick();
    idle();
    ra1 = 5'd5; ra2 = 5'd6;
    #1;
    chk("dual_rd1", bus_b.rd1, 32'h1111_1111);
    chk("dual_rd2", bus_b.rd2, 32'h2222_2222);
    chk("dual_nb_rd2", bus_n.rd2, 32'h2222_2222);
    we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h0000_AAAA;
    we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h0000_BBBB;
    ra1 = 5'd7;
    #1;
    chk("coll_bypass_rd1", bus_b.rd1, 32'h0000_BBBB);
    chk("coll_nb_old_rd1", bus_n.rd1, 32'h0);
    tick();
    idle();
    #1;
    chk("coll_rd1", bus_b.rd1, 32'h0000_BBBB);
    chk("coll_nb_rd1", bus_n.rd1, 32'h0000_BBBB);

    // 3. Bypass, compared against the no-bypass instance.
    ra1 = 5'd9;
    we_a = 1'b1; wa_a = 5'd9; wd_a = 32'hDEAD_BEEF;
    #1;
    chk("byp_rd1", bus_b.rd1, 32'hDEAD_BEEF);
    chk("nobyp_old_rd1", bus_n.rd1, 32'h0);
    tick();
    idle();
    #1;
    chk("nobyp_new_rd1", bus_n.rd1, 32'hDEAD_BEEF);

    // 4. Zero register: writes, issues, reads and the debug tap all stay zero.
    we_b = 1'b1; wa_b = 5'd0; wd_b = 32'hFFFF_FFFF;
    iss_en = 1'b1; iss_rd = 5'd0;
    ra1 = 5'd0; dbg_sel = 5'd0;
    #1;
    chk("zero_byp_rd1", bus_b.rd1, 32'h0);
    tick();
    idle();
    #1;
    chk("zero_rd1", bus_b.rd1, 32'h0);
    chk("zero_busy1", {31'b0, bus_b.busy1}, 32'h0);
    chk("zero_dbg", bus_b.dbg_data, 32'h0);

    // The debug tap reads a stored register. It also sees a write made on the
    // same edge.
    dbg_sel = 5'd9;
    tick();
    chk("dbg_r9", bus_b.dbg_data, 32'hDEAD_BEEF);
    dbg_sel = 5'd11;
    we_a = 1'b1; wa_a = 5'd11; wd_a = 32'h0000_CAFE;
    tick();
    idle();
    chk("dbg_same_edge", bus_b.dbg_data, 32'h0000_CAFE);
    chk("dbg_same_edge_nb", bus_n.dbg_data, 32'h0000_CAFE);

    // Address 30 is out of range for u_nb (24 registers) but valid for u_dut.
    we_a = 1'b1; wa_a = 5'd30; wd_a = 32'h0000_0077;
    iss_en = 1'b1; iss_rd = 5'd30;
    ra1 = 5'd30; dbg_sel = 5'd30;
    tick();
    idle();
    #1;
    chk("oor_nb_rd1", bus_n.rd1, 32'h0);
    chk("oor_nb_busy1", {31'b0, bus_n.busy1}, 32'h0);
    chk("oor_nb_dbg", bus_n.dbg_data, 32'h0);
    chk("oor_dut_rd1", bus_b.rd1, 32'h0000_0077);
    chk("oor_dut_busy1", {31'b0, bus_b.busy1}, 32'd1);

    // 5. Scoreboard: issue sets the bit, a write clears it on the next cycle,
    //    and an issue in the same cycle as a write wins.
    iss_en = 1'b1; iss_rd = 5'd12; ra1 = 5'd12;
    tick();
    idle();
    #1;
    chk("sb_set", {31'b0, bus_b.busy1}, 32'd1);
    we_a = 1'b1; wa_a = 5'd12; wd_a = 32'h0000_0001;
    #1;
    chk("sb_no_bypass", {31'b0, bus_b.busy1}, 32'd1);
    tick();
    idle();
    #1;
    chk("sb_clear", {31'b0, bus_b.busy1}, 32'h0);
    iss_en = 1'b1; iss_rd = 5'd12;
    we_b = 1'b1; wa_b = 5'd12; wd_b = 32'h0000_0C0C;
    tick();
    idle();
    #1;
    chk("sb_issue_wins", {31'b0, bus_b.busy1}, 32'd1);
    chk("sb_issue_wins_nb", {31'b0, bus_n.busy1}, 32'd1);
    chk("sb_issue_wr_rd1", bus_b.rd1, 32'h0000_0C0C);

    // 6. Reset in the middle of operation discards that cycle's writes and
    //    issue.
    iss_en = 1'b1; iss_rd = 5'd3;
    tick();
    idle();
    ra1 = 5'd3;
    #1;
    chk("pre_rst_busy3", {31'b0, bus_b.busy1}, 32'd1);
    rst = 1'b1;
    we_a = 1'b1; wa_a = 5'd3; wd_a = 32'h0000_0055;
    we_b = 1'b1; wa_b = 5'd4; wd_b = 32'h0000_0066;
    iss_en = 1'b1; iss_rd = 5'd3;
    tick();
    rst = 1'b0;
    idle();
    ra1 = 5'd3; ra2 = 5'd4;
    #1;
    chk("mid_rst_r3", bus_b.rd1, 32'h0);
    chk("mid_rst_r4", bus_b.rd2, 32'h0);
    chk("mid_rst_busy3", {31'b0, bus_b.busy1}, 32'h0);
    ra1 = 5'd5; ra2 = 5'd12;
    #1;
    chk("mid_rst_r5", bus_b.rd1, 32'h0);
    chk("mid_rst_busy12", {31'b0, bus_b.busy2}, 32'h0);
    chk("mid_rst_nb_r5", bus_n.rd1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
